// File: rtl/blit_regs_if.sv
// rtl/blit_regs_if.sv - router-to-register-file request/ack bus
interface blit_regs_if;
  logic        req;
  logic [7:0]  addr;
  logic [15:0] wdata;
  logic [1:0]  wstrb;
  logic        we;
  logic        ack;
  logic [15:0] rdata;

  modport master (
    output req, addr, wdata, wstrb, we,
    input  ack, rdata
  );

  modport slave (
    input  req, addr, wdata, wstrb, we,
    output ack, rdata
  );
endinterface

// File: rtl/blit_regs.sv
// rtl/blit_regs.sv - display/vblank/irq registers and keyboard receive FIFO
// Every request is acked one cycle later; irq is a registered level.
module blit_regs #(
  parameter int KBD_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rstn,
  blit_regs_if.slave  regs,
  input  logic        vblank,
  input  logic        kbd_valid,
  input  logic [7:0]  kbd_data,
  output logic        kbd_ready,
  output logic [15:0] disp_base,
  output logic        irq
);

  localparam int PW = $clog2(KBD_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(KBD_DEPTH);

  localparam logic [6:0] W_DADDR  = 7'h00;
  localparam logic [6:0] W_STAT   = 7'h01;
  localparam logic [6:0] W_MASK   = 7'h02;
  localparam logic [6:0] W_KDATA  = 7'h03;
  localparam logic [6:0] W_KCOUNT = 7'h04;
  localparam logic [6:0] W_TICKS  = 7'h05;

  logic [15:0]   daddr_q, daddr_d;
  logic          vbl_q, vbl_d;
  logic [1:0]    mask_q, mask_d;
  logic [15:0]   ticks_q, ticks_d;
  logic          vblank_q;
  logic [7:0]    mem_q [KBD_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ack_q;
  logic [15:0]   rdata_q, rdata_d;
  logic          irq_q, irq_d;

  logic [6:0] word;
  logic       rd_req, wr_req;
  logic       vbl_rise;
  logic       kbd_nonempty;
  logic       push, pop;
  logic       ticks_wr;
  logic       unused_addr0;

  assign unused_addr0 = regs.addr[0];
  assign word         = regs.addr[7:1];
  assign rd_req       = regs.req & ~regs.we;
  assign wr_req       = regs.req & regs.we;
  assign vbl_rise     = vblank & ~vblank_q;
  assign kbd_nonempty = (count_q != '0);
  assign kbd_ready    = (count_q != FULL_COUNT);
  assign push         = kbd_valid & kbd_ready;
  // Pop decision uses the registered count, so a byte arriving this cycle is not visible yet.
  assign pop          = rd_req & (word == W_KDATA) & kbd_nonempty;
  assign ticks_wr     = wr_req & (word == W_TICKS) & (regs.wstrb != 2'b00);

  always_comb begin
    rdata_d = rdata_q;
    if (rd_req) begin
      case (word)
        W_DADDR:  rdata_d = daddr_q;
        W_STAT:   rdata_d = {14'b0, kbd_nonempty, vbl_q};
        W_MASK:   rdata_d = {14'b0, mask_q};
        W_KDATA:  rdata_d = kbd_nonempty ? {8'h80, mem_q[rd_ptr_q]} : 16'h0000;
        W_KCOUNT: rdata_d = 16'(count_q);
        W_TICKS:  rdata_d = ticks_q;
        default:  rdata_d = 16'h0000;
      endcase
    end
  end

  always_comb begin
    daddr_d = daddr_q;
    mask_d  = mask_q;
    vbl_d   = vbl_q;
    ticks_d = ticks_q;
    if (wr_req && word == W_DADDR) begin
      if (regs.wstrb[0]) daddr_d[7:0]  = regs.wdata[7:0];
      if (regs.wstrb[1]) daddr_d[15:8] = regs.wdata[15:8];
    end
    if (wr_req && word == W_MASK && regs.wstrb[0]) begin
      mask_d = regs.wdata[1:0];
    end
    if (wr_req && word == W_STAT && regs.wstrb[0] && regs.wdata[0]) begin
      vbl_d = 1'b0;
    end
    // Edge set is applied after the clear so a colliding edge keeps VBL high.
    if (vbl_rise) begin
      vbl_d = 1'b1;
    end
    if (ticks_wr) begin
      if (regs.wstrb[0]) ticks_d[7:0]  = regs.wdata[7:0];
      if (regs.wstrb[1]) ticks_d[15:8] = regs.wdata[15:8];
    end else if (vbl_rise) begin
      ticks_d = ticks_q + 16'd1;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q + PW'(push);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    count_d  = count_q + CW'(push) - CW'(pop);
    irq_d    = |({kbd_nonempty, vbl_q} & mask_q);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      daddr_q  <= '0;
      vbl_q    <= 1'b0;
      mask_q   <= '0;
      ticks_q  <= '0;
      vblank_q <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ack_q    <= 1'b0;
      rdata_q  <= '0;
      irq_q    <= 1'b0;
    end else begin
      daddr_q  <= daddr_d;
      vbl_q    <= vbl_d;
      mask_q   <= mask_d;
      ticks_q  <= ticks_d;
      vblank_q <= vblank;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ack_q    <= regs.req;
      rdata_q  <= rdata_d;
      irq_q    <= irq_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= kbd_data;
    end
  end

  assign regs.ack   = ack_q;
  assign regs.rdata = rdata_q;
  assign disp_base  = daddr_q;
  assign irq        = irq_q;

endmodule

// File: tb/tb_blit_regs.sv
// tb/tb_blit_regs.sv - scoreboard bench for blit_regs with a queue-based reference model
module tb_blit_regs;
  localparam int D = 8;

  logic        clk = 1'b0;
  logic        rstn;
  logic        vblank;
  logic        kbd_valid;
  logic [7:0]  kbd_data;
  logic        kbd_ready;
  logic [15:0] disp_base;
  logic        irq;

  always #5 clk = ~clk;

  blit_regs_if bus ();

  blit_regs #(.KBD_DEPTH(D)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .regs      (bus),
    .vblank    (vblank),
    .kbd_valid (kbd_valid),
    .kbd_data  (kbd_data),
    .kbd_ready (kbd_ready),
    .disp_base (disp_base),
    .irq       (irq)
  );

  typedef struct {
    int          due;
    bit          is_read;
    logic [15:0] data;
    logic [7:0]  addr;
  } exp_t;

  exp_t sbq[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;

  // reference model state
  logic [15:0] m_daddr, m_ticks;
  logic        m_vbl, m_vbprev, m_irq;
  logic [1:0]  m_mask;
  logic [7:0]  kq[$];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at t=%0t", name, act, exp, $time);
    end
  endfunction

  task automatic model_reset();
    m_daddr = 0; m_ticks = 0; m_vbl = 0; m_vbprev = 0; m_irq = 0; m_mask = 0;
    kq.delete();
    sbq.delete();
  endtask

  // Monitor: every ack must match the oldest outstanding request due this cycle.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (bus.ack === 1'b1) begin
        if (sbq.size() > 0 && sbq[0].due == cyc) begin
          exp_t e;
          e = sbq.pop_front();
          if (e.is_read) chk($sformatf("rdata@%02h", e.addr), bus.rdata, e.data);
          else           chk($sformatf("wack@%02h", e.addr), bus.ack, 1);
        end else begin
          chk("unexpected_ack", bus.ack, 0);
        end
      end
      if (sbq.size() > 0 && sbq[0].due <= cyc) begin
        chk($sformatf("missing_ack@%02h", sbq[0].addr), bus.ack, 1);
        void'(sbq.pop_front());
      end
    end
  end

  // One bus cycle: drive at posedge+2, check state outputs, advance the model, wait.
  task automatic step(input bit req, input bit we, input logic [7:0] addr,
                      input logic [15:0] wdata, input logic [1:0] wstrb);
    bit          ready, ne, rise, tw;
    logic        irq_n;
    logic [15:0] rd;
    exp_t        e;
    bus.req = req; bus.we = we; bus.addr = addr; bus.wdata = wdata; bus.wstrb = wstrb;
    #1;
    chk("kbd_ready", kbd_ready, (kq.size() != D));
    chk("irq", irq, m_irq);
    chk("disp_base", disp_base, m_daddr);
    ready = (kq.size() < D);
    ne    = (kq.size() > 0);
    irq_n = |({ne, m_vbl} & m_mask);
    rise  = vblank && !m_vbprev;
    tw    = 0;
    if (req) begin
      e.due = cyc + 1; e.is_read = !we; e.addr = addr; e.data = 16'h0;
      if (!we) begin
        case (addr[7:1])
          7'h00: rd = m_daddr;
          7'h01: rd = {14'b0, ne, m_vbl};
          7'h02: rd = {14'b0, m_mask};
          7'h03: if (ne) rd = {8'h80, kq.pop_front()}; else rd = 16'h0;
          7'h04: rd = 16'(kq.size());
          7'h05: rd = m_ticks;
          default: rd = 16'h0;
        endcase
        e.data = rd;
      end else begin
        case (addr[7:1])
          7'h00: begin
            if (wstrb[0]) m_daddr[7:0]  = wdata[7:0];
            if (wstrb[1]) m_daddr[15:8] = wdata[15:8];
          end
          7'h01: if (wstrb[0] && wdata[0]) m_vbl = 0;
          7'h02: if (wstrb[0]) m_mask = wdata[1:0];
          7'h05: begin
            tw = (wstrb != 2'b00);
            if (wstrb[0]) m_ticks[7:0]  = wdata[7:0];
            if (wstrb[1]) m_ticks[15:8] = wdata[15:8];
          end
          default: ;
        endcase
      end
      sbq.push_back(e);
    end
    if (rise) begin
      m_vbl = 1;
      if (!tw) m_ticks = m_ticks + 16'd1;
    end
    if (kbd_valid && ready) kq.push_back(kbd_data);
    m_irq    = irq_n;
    m_vbprev = vblank;
    @(posedge clk);
    #2;
    bus.req = 0;
  endtask

  task automatic idle();
    step(0, 0, 8'h00, 16'h0, 2'b00);
  endtask

  task automatic rd(input logic [7:0] a);
    step(1, 0, a, 16'h0, 2'b00);
  endtask

  task automatic wr(input logic [7:0] a, input logic [15:0] d, input logic [1:0] s);
    step(1, 1, a, d, s);
  endtask

  task automatic check_reset_outputs(string tag);
    chk({tag, "_ack"}, bus.ack, 0);
    chk({tag, "_rdata"}, bus.rdata, 0);
    chk({tag, "_disp_base"}, disp_base, 0);
    chk({tag, "_irq"}, irq, 0);
    chk({tag, "_kbd_ready"}, kbd_ready, 1);
  endtask

  // Called at posedge+2 (possibly with a request driven); reset lands before the next edge.
  task automatic async_reset();
    #3;
    rstn = 0;
    bus.req = 0; vblank = 0; kbd_valid = 0;
    model_reset();
    #1;
    check_reset_outputs("async_rst");
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("held_rst");
    #1;
    rstn = 1;
  endtask

  initial begin
    rstn = 0; vblank = 0; kbd_valid = 0; kbd_data = 0;
    bus.req = 0; bus.we = 0; bus.addr = 0; bus.wdata = 0; bus.wstrb = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #2;
    check_reset_outputs("por");
    rstn = 1;

    // reset-state reads
    rd(8'h00); rd(8'h02); rd(8'h04); rd(8'h08); rd(8'h0A); idle();

    // byte-strobed DADDR
    wr(8'h00, 16'hABCD, 2'b01); idle();
    wr(8'h00, 16'h12FF, 2'b10); idle();
    rd(8'h01); idle();

    // vblank, mask, W1C and set-wins collision
    wr(8'h04, 16'h0001, 2'b01);
    repeat (3) begin
      vblank = 1; idle(); idle();
      vblank = 0; idle();
    end
    rd(8'h0A); rd(8'h02);
    wr(8'h02, 16'h0001, 2'b01); idle(); idle();
    vblank = 1; wr(8'h02, 16'h0001, 2'b01);
    vblank = 0; idle(); rd(8'h02); idle();
    wr(8'h02, 16'h0001, 2'b00); rd(8'h02);
    // TICKS write collides with an edge: written value wins
    vblank = 1; wr(8'h0A, 16'h1234, 2'b11);
    vblank = 0; rd(8'h0A);
    wr(8'h0A, 16'hFFFF, 2'b11); vblank = 1; idle(); vblank = 0; rd(8'h0A);

    // keyboard FIFO basics
    kbd_valid = 1; kbd_data = 8'h41; idle();
    kbd_data = 8'h42; idle();
    kbd_valid = 0;
    rd(8'h08); rd(8'h06); rd(8'h06); rd(8'h06); rd(8'h08);
    wr(8'h06, 16'hFFFF, 2'b11); rd(8'h08);

    // fill past full, then pop while valid is held
    kbd_valid = 1;
    for (int i = 0; i < D + 1; i++) begin
      kbd_data = 8'h50 + 8'(i);
      idle();
    end
    rd(8'h06); rd(8'h08);
    kbd_valid = 0;
    repeat (D + 1) rd(8'h06);
    rd(8'h08);

    // push into empty FIFO with a simultaneous read
    kbd_valid = 1; kbd_data = 8'h77; rd(8'h06);
    kbd_valid = 0; rd(8'h08); rd(8'h06); rd(8'h08);

    // randomized traffic
    wr(8'h04, 16'h0003, 2'b01);
    for (int i = 0; i < 600; i++) begin
      logic [7:0]  a;
      int          sel;
      if ($urandom_range(0, 3) == 0) vblank = ~vblank;
      kbd_valid = ($urandom_range(0, 2) == 0);
      kbd_data  = 8'($urandom);
      sel = $urandom_range(0, 7);
      case (sel)
        0: a = 8'h00; 1: a = 8'h02; 2: a = 8'h04; 3: a = 8'h06;
        4: a = 8'h08; 5: a = 8'h0A; 6: a = 8'h07;
        default: a = 8'($urandom);
      endcase
      step($urandom_range(0, 9) < 7, $urandom_range(0, 2) == 0, a,
           16'($urandom), 2'($urandom));
    end
    vblank = 0; kbd_valid = 0; idle(); idle();

    // back-to-back, then reset with a request in flight
    rd(8'h0A); rd(8'hFE);
    bus.req = 1; bus.we = 0; bus.addr = 8'h0A;
    async_reset();
    idle(); idle();
    rd(8'h0A); rd(8'h08); idle(); idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
